digest_hex_streamer: RTL and testbench
======================================

DIGEST_HEX_STREAMER -- requirements
Module: digest_hex_streamer

Interface
REQ-001 Parameter DIGEST_W, default 256, SHALL set the digest width in bits; legal values are multiples of 32, from 32 to 512.
REQ-002 Parameter ASCII_OUT, default 0, SHALL select the output form: 0 = raw nibble in HexOut[3:0] with HexOut[7:4]=0; 1 = lowercase ASCII character.
REQ-003 Parameter LSB_FIRST, default 0, SHALL select emit order: 0 = most-significant nibble first; 1 = least-significant nibble first.
REQ-004 Port list SHALL be, clock and reset first:
 Clk  in  1  rising-edge clock.
 Reset  in  1  synchronous, active-high reset.
 Start  in  1  request to capture DigestReg and begin streaming.
 Abort  in  1  terminate the current stream.
 DigestReg  in  DIGEST_W  digest to serialise.
 HexOut  out  8  current nibble or character.
 HexAvailable  out  1  HexOut is valid (valid half of the handshake).
 HexReady  in  1  consumer accepts HexOut (ready half of the handshake).
 EndOfDigest  out  1  high together with the final beat.
 Busy  out  1  high while a stream is in progress.

Function
REQ-005 The block SHALL use a two-state FSM: IDLE and SEND.
REQ-006 In IDLE, Start=1 with Abort=0 SHALL capture DigestReg into an internal shadow register and move the FSM to SEND; the first beat SHALL appear on the next cycle (latency 1).
REQ-007 In SEND, HexAvailable SHALL be 1 and HexOut SHALL be the nibble at the current index, taken from the shadow register and never from the live DigestReg.
REQ-008 A beat SHALL transfer on any cycle where HexAvailable=1 and HexReady=1; the index SHALL then advance one nibble in the order set by LSB_FIRST.
REQ-009 While HexReady=0, HexOut, HexAvailable and EndOfDigest SHALL hold stable.
REQ-010 EndOfDigest SHALL be 1 exactly while the final nibble (index DIGEST_W/4-1 in emit order) is presented.
REQ-011 When the final beat transfers, the FSM SHALL return to IDLE, and HexAvailable, EndOfDigest and Busy SHALL be 0 on the next cycle.
REQ-012 A stream SHALL produce exactly DIGEST_W/4 beats, with no skipped or repeated nibbles.
REQ-013 Busy SHALL equal (state == SEND).
REQ-014 Start while in SEND SHALL be ignored, including on the cycle of the final transfer; back-to-back streams require Start in IDLE.
REQ-015 Abort=1 in SEND SHALL return the FSM to IDLE on the next cycle with all outputs deasserted; any beat handshaking on the Abort cycle counts as delivered.
REQ-016 Abort and Start asserted together in IDLE: Abort SHALL win and no capture SHALL occur.
REQ-017 ASCII mapping SHALL be nibble 0-9 -> 0x30-0x39 and nibble 10-15 -> 0x61-0x66.
REQ-018 The index counter SHALL be $clog2(DIGEST_W/4) bits wide and SHALL never wrap within a stream.
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from HexReady to HexOut.

Reset
REQ-020 Reset=1 on a rising Clk edge SHALL force IDLE, HexOut=0, HexAvailable=0, EndOfDigest=0, Busy=0 and index=0.
REQ-021 Reset SHALL take priority over Start, Abort and any handshake; a reset mid-stream SHALL discard that stream.

Structure
REQ-022 Shared package digest_hex_pkg SHALL hold the FSM state typedef and the ASCII base constants (0x30, 0x61).
REQ-023 Nibble-to-ASCII conversion SHALL be a combinational sub-module, hex_ascii_enc (4-bit in, 8-bit out), bypassed when ASCII_OUT=0.

Verification
REQ-024 Default params, DigestReg=0x0123456789abcdef repeated x4, HexReady=1: 64 beats, values 0,1,...,f repeated; EndOfDigest on beat 64 only; Busy low the cycle after.
REQ-025 ASCII_OUT=1, LSB_FIRST=1, DIGEST_W=32, DigestReg=0xdeadbeef: beats 'f','e','e','b','d','a','e','d' (0x66,0x65,0x65,0x62,0x64,0x61,0x65,0x64).
REQ-026 HexReady toggled pseudo-randomly, DigestReg changed mid-stream: output sequence identical to REQ-024, and HexOut holds while HexReady=0.
REQ-027 Abort after beat 10, then Start with new digest 0xff..ff: outputs idle for 1 cycle, then 64 beats of 0xf.
REQ-028 Reset at beat 20, Start pulsed during SEND, Start+Abort together in IDLE: each returns to or stays in IDLE with all outputs 0 and no extra beats.

Source files
------------

// File: rtl/digest_hex_pkg.sv
// digest_hex_pkg: shared FSM state type and ASCII base constants for the digest hex streamer
package digest_hex_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [7:0] ASCII_DIGIT = 8'h30;
  localparam logic [7:0] ASCII_ALPHA = 8'h61;
endpackage

// File: rtl/hex_ascii_enc.sv
// hex_ascii_enc: combinational nibble to lowercase ASCII hex character
module hex_ascii_enc
  import digest_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  assign ascii = (nibble < 4'd10) ? ASCII_DIGIT + {4'h0, nibble} : ASCII_ALPHA + {4'h0, nibble} - 8'd10;
endmodule

// File: rtl/digest_hex_streamer.sv
// digest_hex_streamer: captures a digest and streams it one nibble per valid/ready beat
module digest_hex_streamer
  import digest_hex_pkg::*;
#(
  parameter int DIGEST_W  = 256,
  parameter int ASCII_OUT = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic [DIGEST_W-1:0] DigestReg,
  output logic [7:0]          HexOut,
  output logic                HexAvailable,
  input  logic                HexReady,
  output logic                EndOfDigest,
  output logic                Busy
);
  localparam int NIB = DIGEST_W / 4;
  localparam int IW = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, pos;
  logic [DIGEST_W-1:0] shadow_q, shadow_d;
  logic [3:0] nib;
  logic [7:0] chr, hex_out_q, hex_out_d;
  logic avail_q, avail_d, eod_q, eod_d;
  generate
    if (ASCII_OUT != 0) begin : g_ascii
      hex_ascii_enc u_enc (.nibble(nib), .ascii(chr));
    end else begin : g_raw
      assign chr = {4'h0, nib};
    end
  endgenerate
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    if (Abort) begin
      state_d = IDLE;
      idx_d = '0;
    end else if (state_q == IDLE && Start) begin
      state_d = SEND;
      idx_d = '0;
      shadow_d = DigestReg;
    end else if (state_q == SEND && HexReady) begin
      state_d = (idx_q == LAST) ? IDLE : SEND;
      idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
    pos = (LSB_FIRST != 0) ? idx_d : LAST - idx_d;
    nib = 4'(shadow_d >> {pos, 2'b00});
    avail_d = state_d == SEND;
    eod_d = avail_d && idx_d == LAST;
    hex_out_d = avail_d ? chr : 8'h00;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      shadow_q <= '0;
      hex_out_q <= '0;
      avail_q <= 1'b0;
      eod_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      hex_out_q <= hex_out_d;
      avail_q <= avail_d;
      eod_q <= eod_d;
    end
  end
  assign HexOut = hex_out_q;
  assign HexAvailable = avail_q;
  assign EndOfDigest = eod_q;
  assign Busy = state_q == SEND;
endmodule

// File: tb/tb_digest_hex_streamer.sv
// tb_digest_hex_streamer: table-driven and model-checked bench for digest_hex_streamer
module tb_digest_hex_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic start_a, abort_a, ready_a, avail_a, eod_a, busy_a;
  logic [255:0] digest_a;
  logic [7:0] hex_a;
  logic start_b, abort_b, ready_b, avail_b, eod_b, busy_b;
  logic [31:0] digest_b;
  logic [7:0] hex_b;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic start;
    logic abort;
    logic ready;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[15];
  digest_hex_streamer dut_a (
    .Clk(clk), .Reset(rst), .Start(start_a), .Abort(abort_a), .DigestReg(digest_a),
    .HexOut(hex_a), .HexAvailable(avail_a), .HexReady(ready_a), .EndOfDigest(eod_a), .Busy(busy_a)
  );
  digest_hex_streamer #(.DIGEST_W(32), .ASCII_OUT(1), .LSB_FIRST(1)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start_b), .Abort(abort_b), .DigestReg(digest_b),
    .HexOut(hex_b), .HexAvailable(avail_b), .HexReady(ready_b), .EndOfDigest(eod_b), .Busy(busy_b)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] hexval(input byte c);
    return (c >= "a") ? 4'(c - "a" + 10) : 4'(c - "0");
  endfunction
  function automatic logic [10:0] act(input logic [7:0] c, input logic e);
    return {1'b1, c, e, 1'b1};
  endfunction
  function automatic vec_t mk(input logic s, input logic a, input logic r, input logic [10:0] e);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.ready = r;
    v.exp = e;
    return v;
  endfunction
  task automatic stream_a(input logic [255:0] d, input bit rnd, input bit scramble, input int kill_at, input bit kill_rst);
    string s;
    int beats;
    int cyc;
    logic [7:0] prev_out;
    bit prev_hold;
    s = $sformatf("%064h", d);
    digest_a = d;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    beats = 0;
    prev_hold = 0;
    prev_out = 8'h00;
    for (cyc = 0; cyc < 2000 && avail_a; cyc++) begin
      if (prev_hold) check("hold", {24'h0, hex_a}, {24'h0, prev_out});
      check($sformatf("beat%0d", beats), {22'h0, hex_a, eod_a, busy_a},
            {22'h0, 4'h0, hexval(s[beats]), beats == 63, 1'b1});
      ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beats == kill_at - 1) begin
        ready_a = 1'b1;
        if (kill_rst) begin
          rst = 1'b1;
          start_a = 1'b1;
        end else abort_a = 1'b1;
      end
      prev_hold = !ready_a;
      prev_out = hex_a;
      if (ready_a) beats++;
      if (scramble) digest_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      rst = 1'b0;
      abort_a = 1'b0;
      start_a = 1'b0;
      ready_a = 1'b0;
    end
    check("timeout", {31'h0, cyc < 2000}, 32'h1);
    check("beat_count", beats, (kill_at > 0) ? kill_at : 64);
    check("idle_after", {21'h0, avail_a, eod_a, busy_a, hex_a}, 32'h0);
  endtask
  initial begin
    logic [255:0] pat;
    rst = 1'b1;
    {start_a, abort_a, ready_a, start_b, abort_b, ready_b} = '0;
    digest_a = '0;
    digest_b = 32'hdeadbeef;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", {21'h0, avail_a, eod_a, busy_a, hex_a}, 32'h0);
    check("reset_b", {21'h0, avail_b, eod_b, busy_b, hex_b}, 32'h0);
    rst = 1'b0;
    tbl[0] = mk(1, 0, 0, act(8'h66, 0));
    tbl[1] = mk(0, 0, 1, act(8'h65, 0));
    tbl[2] = mk(0, 0, 0, act(8'h65, 0));
    tbl[3] = mk(0, 0, 1, act(8'h65, 0));
    tbl[4] = mk(0, 0, 1, act(8'h62, 0));
    tbl[5] = mk(1, 0, 1, act(8'h64, 0));
    tbl[6] = mk(0, 0, 1, act(8'h61, 0));
    tbl[7] = mk(0, 0, 1, act(8'h65, 0));
    tbl[8] = mk(0, 0, 1, act(8'h64, 1));
    tbl[9] = mk(0, 0, 0, act(8'h64, 1));
    tbl[10] = mk(1, 0, 1, 11'h0);
    tbl[11] = mk(1, 1, 0, 11'h0);
    tbl[12] = mk(1, 0, 0, act(8'h66, 0));
    tbl[13] = mk(0, 1, 1, 11'h0);
    tbl[14] = mk(0, 0, 1, 11'h0);
    for (int i = 0; i < 15; i++) begin
      digest_b = (i >= 1 && i < 11) ? 32'h12345678 : 32'hdeadbeef;
      start_b = tbl[i].start;
      abort_b = tbl[i].abort;
      ready_b = tbl[i].ready;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {21'h0, avail_b, hex_b, eod_b, busy_b}, {21'h0, tbl[i].exp});
    end
    {start_b, abort_b, ready_b} = '0;
    pat = {4{64'h0123456789abcdef}};
    stream_a(pat, 0, 0, 0, 0);
    stream_a(pat, 1, 1, 0, 0);
    stream_a(pat, 0, 0, 10, 0);
    stream_a({256{1'b1}}, 1, 0, 0, 0);
    stream_a(pat, 1, 0, 20, 1);
    start_a = 1'b1;
    abort_a = 1'b1;
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("start_abort_idle", {21'h0, avail_a, eod_a, busy_a, hex_a}, 32'h0);
    start_a = 1'b0;
    abort_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("still_idle", {21'h0, avail_a, eod_a, busy_a, hex_a}, 32'h0);
    ready_a = 1'b0;
    repeat (3) stream_a({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
